// File: rtl/iram_mp.sv
// Multi-port instruction RAM with program-load and clear modes; 1-cycle fetch latency per port.
// No core backpressure; the loader is stalled (prog_ready=0) outside LOAD and dropped writes still handshake.
module iram_mp #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 65536,
    parameter int NUM_PORTS = 4,
    parameter int NOP_WORD  = 41
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          core_rd,
    input  logic [NUM_PORTS*ADDR_W-1:0]   core_addr,
    output logic [NUM_PORTS*DATA_W-1:0]   core_data,
    output logic [NUM_PORTS-1:0]          core_valid,
    output logic [NUM_PORTS-1:0]          core_err,
    input  logic                          load_req,
    input  logic                          clear_req,
    input  logic                          prog_valid,
    output logic                          prog_ready,
    input  logic [ADDR_W-1:0]             prog_addr,
    input  logic [DATA_W-1:0]             prog_data,
    output logic [ADDR_W:0]               wr_count,
    output logic                          busy
);

    typedef enum logic [1:0] {RUN, LOAD, CLEAR} state_t;

    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] NOP       = DATA_W'(NOP_WORD);
    localparam logic [ADDR_W:0]   WR_MAX    = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic              prog_fire, prog_in_range;
    logic              enter_load, enter_clear;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] rd_addr     [NUM_PORTS];
    logic              rd_in_range [NUM_PORTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (clear_req)     state_nxt = CLEAR;
                else if (load_req) state_nxt = LOAD;
            end
            LOAD:    if (!load_req)            state_nxt = RUN;
            CLEAR:   if (clr_cnt == LAST_ADDR) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        prog_ready    = (state == LOAD);
        busy          = (state != RUN);
        enter_load    = (state == RUN) && (state_nxt == LOAD);
        enter_clear   = (state == RUN) && (state_nxt == CLEAR);
        prog_in_range = ({1'b0, prog_addr} < DEPTH_L);
        prog_fire     = prog_valid && prog_ready;
        mem_we        = 1'b0;
        mem_waddr     = prog_addr;
        mem_wdata     = prog_data;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt;
            mem_wdata = NOP;
        end else if (prog_fire && prog_in_range) begin
            mem_we    = 1'b1;
        end
    end

    // Storage has no reset: contents survive rst_n and an aborted CLEAR.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (state == CLEAR && clr_cnt != LAST_ADDR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end else begin
            clr_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (enter_load) begin
            wr_count <= '0;
        end else if (prog_fire && prog_in_range && wr_count != WR_MAX) begin
            wr_count <= wr_count + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            rd_addr[i]     = core_addr[i*ADDR_W +: ADDR_W];
            rd_in_range[i] = ({1'b0, rd_addr[i]} < DEPTH_L);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_data  <= '0;
            core_valid <= '0;
            core_err   <= '0;
        end else begin
            core_valid <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (state == RUN && core_rd[i]) begin
                    core_valid[i] <= 1'b1;
                    if (rd_in_range[i]) begin
                        core_data[i*DATA_W +: DATA_W] <= mem[rd_addr[i]];
                    end else begin
                        core_data[i*DATA_W +: DATA_W] <= NOP;
                        core_err[i]                   <= 1'b1;
                    end
                end
            end
            // Entering CLEAR wipes the sticky error flags, even over a same-cycle fault.
            if (enter_clear) core_err <= '0;
        end
    end

endmodule

// File: doc/iram_mp.md
IRAM_MP -- requirements
Module: iram_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning address width.
REQ-003 SHALL have parameter DEPTH, default 65536, meaning number of words, where DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter NUM_PORTS, default 4, meaning number of core fetch ports.
REQ-005 SHALL have parameter NOP_WORD, default 41, meaning fill value for clear and for out-of-range reads.
REQ-006 SHALL have the following ports, with clk and rst_n first; the single clock is clk, and the reset is rst_n, asynchronous, active-low:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_rd  in  NUM_PORTS  per-port fetch request.
- core_addr  in  NUM_PORTS*ADDR_W  packed fetch addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- core_data  out  NUM_PORTS*DATA_W  packed fetched words.
- core_valid  out  NUM_PORTS  per-port one-cycle data-valid pulse.
- core_err  out  NUM_PORTS  per-port sticky out-of-range flag.
- load_req  in  1  request or hold program-load mode.
- clear_req  in  1  request fill of the whole array with NOP_WORD.
- prog_valid  in  1  loader write valid.
- prog_ready  out  1  loader write ready.
- prog_addr  in  ADDR_W  loader write address.
- prog_data  in  DATA_W  loader write data.
- wr_count  out  ADDR_W+1  number of words accepted in the current load session.
- busy  out  1  high when the block is not in RUN.

Function
REQ-007 SHALL implement a three-state FSM with states RUN, LOAD and CLEAR.
REQ-008 SHALL transition from RUN to CLEAR when clear_req=1, to LOAD when load_req=1 and clear_req=0, and otherwise stay in RUN; when both requests are high, clear SHALL win.
REQ-009 SHALL, in LOAD, drive prog_ready=1 combinationally.
REQ-010 SHALL, in every state other than LOAD, drive prog_ready=0.
REQ-011 SHALL write mem[prog_addr]<=prog_data on each edge where prog_valid & prog_ready and prog_addr<DEPTH.
REQ-012 SHALL increment wr_count on each accepted write and saturate it at 2**ADDR_W.
REQ-013 SHALL drop a write with prog_addr>=DEPTH while still handshaking it, and SHALL NOT increment wr_count for that write.
REQ-014 SHALL transition from LOAD to RUN on the edge where load_req=0, and SHALL still accept a handshake occurring in that same cycle.
REQ-015 SHALL clear wr_count to 0 on every entry to LOAD, and SHALL hold wr_count in RUN.
REQ-016 SHALL, in CLEAR, write NOP_WORD to address clr_cnt with clr_cnt running 0..DEPTH-1 at one word per cycle, then transition to RUN after the write to DEPTH-1, taking exactly DEPTH cycles.
REQ-017 SHALL ignore load_req and clear_req while in CLEAR.
REQ-018 SHALL drive busy=1 in LOAD and CLEAR, and busy=0 in RUN.
REQ-019 SHALL, in RUN, respond to core_rd[i]=1 at edge N with core_data[i]=mem[addr_i] and core_valid[i]=1 at edge N+1, giving 1-cycle latency with all ports independent and concurrent.
REQ-020 SHALL serve identical addresses on several ports in the same cycle without stall.
REQ-021 SHALL serve a read issued in the final RUN cycle before a transition normally.
REQ-022 SHALL, in LOAD or CLEAR, ignore core_rd and drive core_valid=0.
REQ-023 SHALL drive core_valid[i]=0 whenever no read was accepted on port i in the previous cycle, with core_data[i] holding its last value.
REQ-024 SHALL, for a RUN read with addr_i>=DEPTH, return NOP_WORD with core_valid[i]=1 and set core_err[i]=1 sticky; core_err[i] SHALL clear only on reset or on entry to CLEAR.
REQ-025 SHALL make memory contents undefined at power-up unless loaded or cleared, and SHALL NOT implement any hard-coded program image.

Reset
REQ-026 SHALL, while rst_n=0, force state=RUN, core_data=0, core_valid=0, core_err=0, wr_count=0, clr_cnt=0, busy=0 and prog_ready=0, asynchronously.
REQ-027 SHALL leave memory contents unchanged on reset.
REQ-028 SHALL abort an in-progress CLEAR or LOAD on reset, leaving words already written intact, and SHALL NOT resume it after rst_n rises.
REQ-029 SHALL return to normal operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-030 SHALL be verified by the following directed scenarios, using DEPTH=256, ADDR_W=8, NUM_PORTS=4:
- Scenario 1: clear_req pulse -> busy=1 for 256 cycles, then busy=0; a read of addr 200 on any port returns 41.
- Scenario 2: load_req=1; write (0,45),(1,5),(2,51),(3,10),(4,40) with prog_valid held -> 5 handshakes, wr_count=5; load_req=0 -> RUN.
- Scenario 3: In RUN, ports 0..3 read addrs 0,1,0,4 in the same cycle -> next cycle valid=4'b1111, data 45,5,45,40; a second cycle with no core_rd -> valid=0, data held.
- Scenario 4: Assert load_req and clear_req together in RUN -> CLEAR entered and prog_ready stays 0; a read issued during CLEAR -> core_valid=0.
- Scenario 5: With DEPTH=200, read addr 250 on port 2 -> data 41, valid=1, core_err[2]=1 and stays 1 after later in-range reads; a prog write to addr 220 -> handshaken, wr_count unchanged.
- Scenario 6: Drop rst_n mid-CLEAR at clr_cnt=100 -> outputs at reset values immediately, state RUN after release, words 0..99=41 and word 150 unchanged.
